// File: rtl/display_defs.sv
// Shared constants for the digit scan controller: register map, FSM encoding,
// default timing parameters and the digit-select decode.
package display_defs;

  localparam int DEF_SCAN_DIV  = 100000;
  localparam int DEF_BLANK_CYC = 1000;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_LEDS  = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot-phase cycle counter: counts out the BLANK or DRIVE phase length and
// flags the last cycle of the phase; wraps to zero on every phase change.
module scan_timer
  import display_defs::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic blank,
  output logic tc
);

  // Longest phase is at most SCAN_DIV-1 cycles, so counts up to SCAN_DIV-2 fit.
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (blank ? BLANK_LAST : DRIVE_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  cnt <= '0;
    else if (tc) cnt <= '0;
    else         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed display scanner with blanking between digits and
// frame-synchronous shadowing of the displayed value/mask.
module digit_scan_ctrl
  import display_defs::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [7:0]  leds,
  output logic [3:0]  AN,
  output logic [3:0]  BCD,
  output logic        frame_start
);

  if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_param
    $error("digit_scan_ctrl: need 1 <= BLANK_CYC < SCAN_DIV");
  end

  scan_state_t state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        tc, frame_edge, freeze;
  logic [15:0] pend_val, shad_val, shad_val_nxt;
  logic [3:0]  pend_mask, shad_mask, shad_mask_nxt;

  scan_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk   (clk),
    .reset (reset),
    .blank (state == BLANK),
    .tc    (tc)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    frame_edge = 1'b0;
    case (state)
      BLANK: if (tc) begin
        state_nxt  = DRIVE;
        frame_edge = (idx == 2'd0);
      end
      DRIVE: if (tc) begin
        state_nxt = BLANK;
        idx_nxt   = idx + 2'd1;
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BLANK;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Shadow captures the pre-write pending value, so a same-cycle write lands a frame later.
  assign shad_val_nxt  = (frame_edge && !freeze) ? pend_val  : shad_val;
  assign shad_mask_nxt = (frame_edge && !freeze) ? pend_mask : shad_mask;

  // Outputs are decoded from next-state values so they align with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shad_val    <= 16'h0000;
      shad_mask   <= 4'hF;
      AN          <= 4'hF;
      BCD         <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      shad_val    <= shad_val_nxt;
      shad_mask   <= shad_mask_nxt;
      frame_start <= frame_edge;
      if (state_nxt == DRIVE) begin
        AN  <= ~(onehot4(idx) & shad_mask_nxt);
        BCD <= shad_val_nxt[{idx, 2'b00} +: 4];
      end else begin
        AN  <= 4'hF;
        BCD <= 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_val  <= 16'h0000;
      pend_mask <= 4'hF;
      leds      <= 8'h00;
      freeze    <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_VALUE: pend_val  <= wr_data;
        ADDR_MASK:  pend_mask <= wr_data[3:0];
        ADDR_LEDS:  leds      <= wr_data[7:0];
        default:    freeze    <= wr_data[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= 16'h0000;
    end else begin
      case (rd_addr)
        ADDR_VALUE: rd_data <= pend_val;
        ADDR_MASK:  rd_data <= {12'h000, pend_mask};
        ADDR_LEDS:  rd_data <= {8'h00, leds};
        default:    rd_data <= {15'h0000, freeze};
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [15:0] wr_data = 16'h0;
  logic [1:0]  rd_addr = 2'd0;
  logic [15:0] rd_data;
  logic [7:0]  leds;
  logic [3:0]  AN, BCD;
  logic        frame_start;

  int e;        // rising edges since reset release
  int n_pass;
  int n_total;

  digit_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .leds        (leds),
    .AN          (AN),
    .BCD         (BCD),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  task automatic write(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Frame position p: 0-1 blank d0, 2-7 drive d0, 8-9 blank d1, ... 26-31 drive d3.
  function automatic logic [3:0] exp_an(input int ee, input logic [3:0] m);
    int p;
    p = ee % 32;
    if (p % 8 < 2) return 4'hF;
    return ~(m & (4'b0001 << (p / 8)));
  endfunction

  function automatic logic [3:0] exp_bcd(input int ee, input logic [15:0] v);
    int p;
    p = ee % 32;
    if (p % 8 < 2) return 4'h0;
    return 4'(v >> (4 * (p / 8)));
  endfunction

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_total++; if (AN !== 4'hF) $display("FAIL rst_an got %b exp 1111", AN); else n_pass++;
    n_total++; if (BCD !== 4'h0) $display("FAIL rst_bcd got %h exp 0", BCD); else n_pass++;
    n_total++; if (leds !== 8'h00) $display("FAIL rst_leds got %h exp 00", leds); else n_pass++;
    n_total++; if (rd_data !== 16'h0) $display("FAIL rst_rd got %h exp 0000", rd_data); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL rst_fs got %b exp 0", frame_start); else n_pass++;
    rd_addr = 2'd1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e = 0;
  endtask

  task automatic test_scan();
    while (e <= 15) begin
      n_total++; if (AN !== exp_an(e, 4'hF)) $display("FAIL scan_an e=%0d got %b exp %b", e, AN, exp_an(e, 4'hF)); else n_pass++;
      n_total++; if (frame_start !== (e == 2)) $display("FAIL scan_fs e=%0d got %b exp %b", e, frame_start, (e == 2)); else n_pass++;
      if (e == 1) begin
        n_total++; if (rd_data !== 16'h000F) $display("FAIL rd_mask e=%0d got %h exp 000f", e, rd_data); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_value();
    logic [15:0] v;
    rd_addr = 2'd0;
    write(2'd0, 16'h4321);
    while (e <= 65) begin
      v = (e >= 34) ? 16'h4321 : 16'h0000;
      n_total++; if (AN !== exp_an(e, 4'hF)) $display("FAIL val_an e=%0d got %b exp %b", e, AN, exp_an(e, 4'hF)); else n_pass++;
      n_total++; if (BCD !== exp_bcd(e, v)) $display("FAIL val_bcd e=%0d got %h exp %h", e, BCD, exp_bcd(e, v)); else n_pass++;
      if (e == 17) begin
        n_total++; if (rd_data !== 16'h0000) $display("FAIL rd_old e=%0d got %h exp 0000", e, rd_data); else n_pass++;
      end
      if (e == 18) begin
        n_total++; if (rd_data !== 16'h4321) $display("FAIL rd_new e=%0d got %h exp 4321", e, rd_data); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_mask();
    logic [3:0] m;
    write(2'd1, 16'h0005);
    while (e <= 129) begin
      m = (e >= 98) ? 4'h5 : 4'hF;
      n_total++; if (AN !== exp_an(e, m)) $display("FAIL mask_an e=%0d got %b exp %b", e, AN, exp_an(e, m)); else n_pass++;
      n_total++; if (BCD !== exp_bcd(e, 16'h4321)) $display("FAIL mask_bcd e=%0d got %h exp %h", e, BCD, exp_bcd(e, 16'h4321)); else n_pass++;
      step();
    end
  endtask

  task automatic test_collision();
    logic [15:0] v;
    while (e < 161) step();
    write(2'd0, 16'hABCD);  // lands on the frame-start edge at e=162
    while (e <= 225) begin
      v = (e >= 194) ? 16'hABCD : 16'h4321;
      n_total++; if (AN !== exp_an(e, 4'h5)) $display("FAIL col_an e=%0d got %b exp %b", e, AN, exp_an(e, 4'h5)); else n_pass++;
      n_total++; if (BCD !== exp_bcd(e, v)) $display("FAIL col_bcd e=%0d got %h exp %h", e, BCD, exp_bcd(e, v)); else n_pass++;
      n_total++; if (frame_start !== (e % 32 == 2)) $display("FAIL col_fs e=%0d got %b exp %b", e, frame_start, (e % 32 == 2)); else n_pass++;
      step();
    end
  endtask

  task automatic test_freeze();
    logic [15:0] v;
    write(2'd3, 16'h0001);
    write(2'd0, 16'h9999);
    rd_addr = 2'd3;
    while (e <= 329) begin
      n_total++; if (BCD !== exp_bcd(e, 16'hABCD)) $display("FAIL frz_bcd e=%0d got %h exp %h", e, BCD, exp_bcd(e, 16'hABCD)); else n_pass++;
      n_total++; if (AN !== exp_an(e, 4'h5)) $display("FAIL frz_an e=%0d got %b exp %b", e, AN, exp_an(e, 4'h5)); else n_pass++;
      if (e == 229) begin
        n_total++; if (rd_data !== 16'h0001) $display("FAIL rd_ctrl e=%0d got %h exp 0001", e, rd_data); else n_pass++;
      end
      step();
    end
    write(2'd3, 16'h0000);
    while (e <= 385) begin
      v = (e >= 354) ? 16'h9999 : 16'hABCD;
      n_total++; if (BCD !== exp_bcd(e, v)) $display("FAIL unfrz_bcd e=%0d got %h exp %h", e, BCD, exp_bcd(e, v)); else n_pass++;
      step();
    end
    rd_addr = 2'd0;
    step();
    n_total++; if (rd_data !== 16'h9999) $display("FAIL rd_val got %h exp 9999", rd_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rd_addr = 2'd2;
    write(2'd2, 16'h005A);
    n_total++; if (rd_data !== 16'h0000) $display("FAIL rd_leds_old got %h exp 0000", rd_data); else n_pass++;
    n_total++; if (leds !== 8'h5A) $display("FAIL leds got %h exp 5a", leds); else n_pass++;
    step();
    n_total++; if (rd_data !== 16'h005A) $display("FAIL rd_leds got %h exp 005a", rd_data); else n_pass++;
    while (e % 32 != 20) step();
    n_total++; if (AN !== 4'b1011) $display("FAIL d2_an got %b exp 1011", AN); else n_pass++;
    n_total++; if (BCD !== 4'h9) $display("FAIL d2_bcd got %h exp 9", BCD); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if (AN !== 4'hF) $display("FAIL mid_an got %b exp 1111", AN); else n_pass++;
    n_total++; if (leds !== 8'h00) $display("FAIL mid_leds got %h exp 00", leds); else n_pass++;
    n_total++; if (BCD !== 4'h0) $display("FAIL mid_bcd got %h exp 0", BCD); else n_pass++;
    n_total++; if (rd_data !== 16'h0) $display("FAIL mid_rd got %h exp 0000", rd_data); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    e = 0;
    while (e <= 10) begin
      n_total++; if (AN !== exp_an(e, 4'hF)) $display("FAIL rel_an e=%0d got %b exp %b", e, AN, exp_an(e, 4'hF)); else n_pass++;
      n_total++; if (BCD !== 4'h0) $display("FAIL rel_bcd e=%0d got %h exp 0", e, BCD); else n_pass++;
      step();
    end
  endtask

  initial begin
    e = 0; n_pass = 0; n_total = 0;
    test_reset();
    test_scan();
    test_value();
    test_mask();
    test_collision();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1000, meaning blanking cycles at the start of each digit slot; legal range is 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: register write strobe, accepted every cycle it is high.
REQ-006 The block SHALL have port wr_addr, input, 2 bits: write register select.
REQ-007 The block SHALL have port wr_data, input, 16 bits: write data.
REQ-008 The block SHALL have port rd_addr, input, 2 bits: read register select.
REQ-009 The block SHALL have port rd_data, output, 16 bits: registered read data.
REQ-010 The block SHALL have port leds, output, 8 bits: LED drive.
REQ-011 The block SHALL have port AN, output, 4 bits: digit anodes, active-low.
REQ-012 The block SHALL have port BCD, output, 4 bits: BCD code of the active digit.
REQ-013 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-014 The register map SHALL be:
- addr 0: pending value[15:0], digit i = bits 4i+3:4i.
- addr 1: pending mask[3:0], upper bits ignored.
- addr 2: leds[7:0], applied immediately, not shadowed.
- addr 3: control, bit0 = freeze.
REQ-015 The FSM SHALL have two states, BLANK and DRIVE, with cycle counter cnt and digit index idx (2 bits).
REQ-016 BLANK SHALL last BLANK_CYC cycles, then go to DRIVE with cnt cleared.
REQ-017 DRIVE SHALL last SCAN_DIV-BLANK_CYC cycles, then go to BLANK with idx incremented modulo 4 (3 wraps to 0).
REQ-018 In BLANK, AN SHALL be 4'b1111 and BCD SHALL be 0.
REQ-019 In DRIVE, AN SHALL be ~(onehot(idx) & shadow_mask) and BCD SHALL be shadow_value[4*idx+3:4*idx]; both are registered outputs.
REQ-020 On the BLANK->DRIVE transition with idx==0 (frame start), frame_start SHALL pulse for exactly one cycle.
REQ-021 On that same frame-start edge, the shadow registers SHALL load the pending registers, unless freeze==1.
REQ-022 When a write and a frame-start shadow load occur in the same cycle, the shadow SHALL load the pre-write pending value; the new value appears one frame later.
REQ-023 Shadowed display content SHALL never change mid-frame (no tearing).
REQ-024 rd_data SHALL return the pending register (addr 0/1), leds (addr 2) or control (addr 3), zero-extended, one cycle after rd_addr is presented.
REQ-025 When the same register is read and written in one cycle, rd_data SHALL return the old value.
REQ-026 Illegal parameters SHALL raise an elaboration-time error.

Reset
REQ-027 While reset is low, all outputs SHALL immediately be driven to: AN=4'b1111, BCD=0, leds=0, rd_data=0, frame_start=0.
REQ-028 Reset SHALL initialise: pending and shadow value 0; pending and shadow mask 4'b1111; freeze 0; state BLANK; idx 0; cnt 0.
REQ-029 Reset asserted mid-DRIVE SHALL abort the slot; after release, scanning SHALL restart at digit 0 from the start of BLANK.

Structure
REQ-030 Register address constants, the state encoding and default parameter values SHALL live in a shared display_defs package/header.
REQ-031 The cnt/terminal-count logic SHALL be one sub-module, scan_timer; all other logic is inline.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-032 The bench SHALL cover: release reset -> AN=1111 for 2 cycles, then AN=1110 for 6 cycles, then 1111 for 2, then 1101 for 6; frame_start high on the 3rd cycle after release only.
REQ-033 The bench SHALL cover: write addr0=0x4321 mid-frame -> current frame unchanged; next frame BCD = 1, 2, 3, 4 for digits 0-3.
REQ-034 The bench SHALL cover: write addr1=0x0005 -> from the next frame, AN stays 1111 during the DRIVE slots of digits 1 and 3.
REQ-035 The bench SHALL cover: write addr0=0xABCD in the same cycle as the frame-start edge -> that frame shows the old value; the following frame shows D, C, B, A.
REQ-036 The bench SHALL cover: write addr3=1, then addr0=0x9999 -> display unchanged for 3 frames; write addr3=0 -> 9999 shown from the next frame; read addr0 returns 0x9999.
REQ-037 The bench SHALL cover: assert reset during DRIVE of digit 2 with leds=0x5A -> AN=1111 and leds=0 in the same cycle, without waiting for a clock edge; after release, scanning resumes at digit 0.
